// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit.
//
// Contents:
//   - Entry record layout.
//     Each in-flight prediction is packed MSB..LSB as {taken, pc[PC_W], target[PC_W]}.
//     entry_w() returns the packed width for a given PC width.
//   - PC_INC: distance to the fall-through instruction.
//   - clog2(): ceiling log2, used to size pointers and the occupancy port.
package branch_pkg;

    localparam int unsigned PC_INC = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int entry_w(input int pc_w);
        return 2 * pc_w + 1;
    endfunction

endpackage

// File: rtl/pred_queue.sv
// Parameterised circular FIFO that holds in-flight branch predictions.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push_i, din_i    write din_i at the tail (caller guarantees not full)
//   pop_i            drop the head entry (caller guarantees not empty)
//   clear_i          discard all entries; wins over push_i and pop_i
//   head_o           oldest entry, valid whenever count_o != 0
//   count_o          number of stored entries, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module pred_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 129,
    localparam int AW   = clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !clear_i;
    assign do_pop  = pop_i && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; count_o gates its validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks conditional branch predictions from IF until
// EX resolves them, then checks the prediction, trains the predictor and
// redirects fetch on a mispredict.
//
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   pred_valid/taken/pc/target         prediction enqueue from IF
//   pred_ready                         queue not full (IF stalls while low)
//   res_valid/taken/target             resolution of the oldest branch from EX
//   flush, redirect_pc                 one-cycle mispredict pulse + correct PC
//   upd_valid, upd_pc, upd_taken       one-cycle predictor training write
//   br_count, mispred_count            saturating statistics
//   err_underflow                      sticky: resolve seen with empty queue
//   occupancy                          entries in flight
//
// Handshake: an enqueue happens on a cycle where pred_valid && pred_ready.
// pred_ready depends only on registered state. pred_valid while pred_ready is
// low is dropped. A resolve happens on a cycle where res_valid is high and the
// queue is non-empty. Results appear one cycle later.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 64,
    parameter int CNT_W   = 32,
    localparam int OCC_W  = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [PC_W-1:0]  pred_pc,
    input  logic [PC_W-1:0]  pred_target,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_target,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic [PC_W-1:0]  upd_pc,
    output logic             upd_taken,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count,
    output logic             err_underflow,
    output logic [OCC_W-1:0] occupancy
);

    localparam int              EW       = entry_w(PC_W);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [EW-1:0]    head;
    logic [EW-1:0]    push_entry;
    logic [OCC_W-1:0] count;
    logic             head_taken;
    logic [PC_W-1:0]  head_pc;
    logic [PC_W-1:0]  head_target;

    logic resolve;
    logic mispredict;
    logic q_push;
    logic q_pop;
    logic q_clear;

    logic             flush_q, flush_d;
    logic [PC_W-1:0]  redirect_q, redirect_d;
    logic             upd_valid_q, upd_valid_d;
    logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
    logic             upd_taken_q, upd_taken_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             err_q, err_d;

    assign push_entry = {pred_taken, pred_pc, pred_target};
    assign {head_taken, head_pc, head_target} = head;

    assign pred_ready = (count != FULL_CNT);
    assign resolve    = res_valid && (count != '0);
    // A taken branch must also have gone to the right place.
    assign mispredict = (head_taken != res_taken) ||
                        (res_taken && (head_target != res_target));

    // A mispredict squashes every younger entry, including one arriving now.
    assign q_clear = resolve && mispredict;
    assign q_pop   = resolve && !mispredict;
    assign q_push  = pred_valid && pred_ready && !q_clear;

    pred_queue #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_pred_queue (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .clear_i (q_clear),
        .din_i   (push_entry),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        flush_d     = 1'b0;
        upd_valid_d = 1'b0;
        redirect_d  = redirect_q;
        upd_pc_d    = upd_pc_q;
        upd_taken_d = upd_taken_q;
        br_cnt_d    = br_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        err_d       = err_q;
        if (resolve) begin
            upd_valid_d = 1'b1;
            upd_pc_d    = head_pc;
            upd_taken_d = res_taken;
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
            if (mispredict) begin
                flush_d    = 1'b1;
                redirect_d = res_taken ? res_target : head_pc + PC_W'(PC_INC);
                if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + CNT_W'(1);
            end
        end else if (res_valid) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            br_cnt_q    <= '0;
            mis_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            upd_valid_q <= upd_valid_d;
            upd_pc_q    <= upd_pc_d;
            upd_taken_q <= upd_taken_d;
            br_cnt_q    <= br_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
            err_q       <= err_d;
        end
    end

    assign flush         = flush_q;
    assign redirect_pc   = redirect_q;
    assign upd_valid     = upd_valid_q;
    assign upd_pc        = upd_pc_q;
    assign upd_taken     = upd_taken_q;
    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;
    assign err_underflow = err_q;
    assign occupancy     = count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit. A queue-based reference model
// tracks in-flight predictions; counters use a narrow width so saturation is
// reachable.
module tb_branch_resolve_unit;

    localparam int DEPTH   = 4;
    localparam int PC_W    = 64;
    localparam int CNT_W   = 4;
    localparam int OCC_W   = 3;
    localparam int CNT_MAX = 15;

    typedef struct {
        logic        taken;
        logic [63:0] pc;
        logic [63:0] target;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             pred_valid, pred_taken, pred_ready;
    logic [PC_W-1:0]  pred_pc, pred_target;
    logic             res_valid, res_taken;
    logic [PC_W-1:0]  res_target;
    logic             flush, upd_valid, upd_taken, err_underflow;
    logic [PC_W-1:0]  redirect_pc, upd_pc;
    logic [CNT_W-1:0] br_count, mispred_count;
    logic [OCC_W-1:0] occupancy;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .pred_target   (pred_target),
        .pred_ready    (pred_ready),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .br_count      (br_count),
        .mispred_count (mispred_count),
        .err_underflow (err_underflow),
        .occupancy     (occupancy)
    );

    // Reference model state
    ent_t        mq[$];
    int          exp_br, exp_mis;
    logic        exp_err, exp_flush, exp_upd, exp_upd_taken;
    logic [63:0] exp_redirect, exp_upd_pc;
    int          n_vec, n_err;

    task automatic model_reset();
        mq.delete();
        exp_br = 0; exp_mis = 0; exp_err = 1'b0;
        exp_flush = 1'b0; exp_upd = 1'b0;
    endtask

    // Applies one cycle of the architectural rules to the model.
    task automatic model_step(input logic pv, input logic pt, input logic [63:0] ppc,
                              input logic [63:0] ptg, input logic rv, input logic rt,
                              input logic [63:0] rtg);
        ent_t h;
        logic mis, ready;
        ent_t e;
        ready = (mq.size() < DEPTH);
        e.taken = pt; e.pc = ppc; e.target = ptg;
        exp_flush = 1'b0;
        exp_upd   = 1'b0;
        if (rv && mq.size() != 0) begin
            h = mq.pop_front();
            mis = (h.taken != rt) || (rt && h.target != rtg);
            exp_upd = 1'b1; exp_upd_pc = h.pc; exp_upd_taken = rt;
            if (exp_br < CNT_MAX) exp_br++;
            if (mis) begin
                exp_flush = 1'b1;
                exp_redirect = rt ? rtg : h.pc + 64'd4;
                if (exp_mis < CNT_MAX) exp_mis++;
                mq.delete();
            end else if (pv && ready) begin
                mq.push_back(e);
            end
        end else begin
            if (rv) exp_err = 1'b1;
            if (pv && ready) mq.push_back(e);
        end
    endtask

    // Drives one cycle of stimulus, then samples 1 time unit after the edge.
    task automatic cyc(input logic pv, input logic pt, input logic [63:0] ppc,
                       input logic [63:0] ptg, input logic rv, input logic rt,
                       input logic [63:0] rtg);
        pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg;
        model_step(pv, pt, ppc, ptg, rv, rt, rtg);
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic enq(input logic pt, input logic [63:0] ppc, input logic [63:0] ptg);
        cyc(1'b1, pt, ppc, ptg, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic res(input logic rt, input logic [63:0] rtg);
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, rt, rtg);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        enq(1'b1, 64'h10, 64'h20);
        enq(1'b0, 64'h14, 64'h30);
        enq(1'b1, 64'h18, 64'h40);
        n_vec++;
        if (occupancy !== 3'd3) begin
            n_err++; $display("FAIL pre_reset_occ: got %0d want 3", occupancy);
        end
        // Reset mid-traffic, asserted away from the clock edge.
        pred_valid = 1'b1; pred_pc = 64'h1c; res_valid = 1'b1; res_taken = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        pred_valid = 1'b0; res_valid = 1'b0;
        n_vec++;
        if (occupancy !== 3'd0 || pred_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_queue: occ=%0d ready=%0b want 0/1", occupancy, pred_ready);
        end
        n_vec++;
        if (flush !== 1'b0 || upd_valid !== 1'b0 || redirect_pc !== 64'd0 ||
            upd_pc !== 64'd0 || upd_taken !== 1'b0) begin
            n_err++; $display("FAIL reset_pulses: flush=%0b upd=%0b rpc=%h upc=%h ut=%0b want all 0",
                              flush, upd_valid, redirect_pc, upd_pc, upd_taken);
        end
        n_vec++;
        if (br_count !== 4'd0 || mispred_count !== 4'd0 || err_underflow !== 1'b0) begin
            n_err++; $display("FAIL reset_counters: br=%0d mis=%0d err=%0b want 0", br_count,
                              mispred_count, err_underflow);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_correct_resolve();
        enq(1'b1, 64'h100, 64'h140);
        res(1'b1, 64'h140);
        n_vec++;
        if (upd_valid !== 1'b1 || upd_pc !== 64'h100 || upd_taken !== 1'b1 || flush !== 1'b0) begin
            n_err++; $display("FAIL correct_upd: upd=%0b pc=%h t=%0b flush=%0b want 1/100/1/0",
                              upd_valid, upd_pc, upd_taken, flush);
        end
        n_vec++;
        if (br_count !== 4'(exp_br) || br_count !== 4'd1) begin
            n_err++; $display("FAIL correct_br_count: got %0d want 1", br_count);
        end
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0);
        n_vec++;
        if (upd_valid !== 1'b0) begin
            n_err++; $display("FAIL upd_pulse_width: got %0b want 0", upd_valid);
        end
    endtask

    task automatic test_mispredict_taken();
        enq(1'b0, 64'h200, 64'h240);
        enq(1'b1, 64'h204, 64'h300);
        enq(1'b0, 64'h208, 64'h400);
        res(1'b1, 64'h180);
        n_vec++;
        if (flush !== 1'b1 || redirect_pc !== 64'h180 || mispred_count !== 4'd1) begin
            n_err++; $display("FAIL mispredict_taken: flush=%0b rpc=%h mis=%0d want 1/180/1",
                              flush, redirect_pc, mispred_count);
        end
        n_vec++;
        if (occupancy !== 3'd0 || upd_pc !== 64'h200) begin
            n_err++; $display("FAIL mispredict_squash: occ=%0d upc=%h want 0/200", occupancy, upd_pc);
        end
        cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0);
        n_vec++;
        if (flush !== 1'b0) begin
            n_err++; $display("FAIL flush_pulse_width: got %0b want 0", flush);
        end
    endtask

    task automatic test_mispredict_same_cycle_enq();
        enq(1'b1, 64'h300, 64'h340);
        cyc(1'b1, 1'b1, 64'h500, 64'h540, 1'b1, 1'b0, 64'h0);
        n_vec++;
        if (flush !== 1'b1 || redirect_pc !== 64'h304) begin
            n_err++; $display("FAIL nottaken_redirect: flush=%0b rpc=%h want 1/304", flush, redirect_pc);
        end
        n_vec++;
        if (occupancy !== 3'd0) begin
            n_err++; $display("FAIL same_cycle_enq_dropped: occ=%0d want 0", occupancy);
        end
        // Enqueue during the flush cycle is a correct-path fetch and is kept.
        enq(1'b0, 64'h600, 64'h640);
        n_vec++;
        if (occupancy !== 3'd1) begin
            n_err++; $display("FAIL enq_after_flush: occ=%0d want 1", occupancy);
        end
        // Target mismatch alone on a correctly-predicted taken branch.
        res(1'b0, 64'h0);
        enq(1'b1, 64'h700, 64'h740);
        res(1'b1, 64'h780);
        n_vec++;
        if (flush !== 1'b1 || redirect_pc !== 64'h780) begin
            n_err++; $display("FAIL target_mismatch: flush=%0b rpc=%h want 1/780", flush, redirect_pc);
        end
    endtask

    task automatic test_pc_wrap();
        enq(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40);
        res(1'b0, 64'h0);
        n_vec++;
        if (flush !== 1'b1 || redirect_pc !== 64'h0) begin
            n_err++; $display("FAIL pc_wrap: flush=%0b rpc=%h want 1/0", flush, redirect_pc);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) enq(1'b1, 64'h800 + 64'(i * 4), 64'h900 + 64'(i * 4));
        n_vec++;
        if (pred_ready !== 1'b0 || occupancy !== 3'd4) begin
            n_err++; $display("FAIL full: ready=%0b occ=%0d want 0/4", pred_ready, occupancy);
        end
        enq(1'b0, 64'hA00, 64'hA40);
        n_vec++;
        if (occupancy !== 3'd4) begin
            n_err++; $display("FAIL full_ignored: occ=%0d want 4", occupancy);
        end
        res(1'b1, 64'h900);
        n_vec++;
        if (pred_ready !== 1'b1 || occupancy !== 3'd3 || flush !== 1'b0 || upd_pc !== 64'h800) begin
            n_err++; $display("FAIL full_resolve: ready=%0b occ=%0d flush=%0b upc=%h want 1/3/0/800",
                              pred_ready, occupancy, flush, upd_pc);
        end
        // Simultaneous enqueue and correct resolve keeps count unchanged.
        cyc(1'b1, 1'b0, 64'hB00, 64'hB40, 1'b1, 1'b1, 64'h904);
        n_vec++;
        if (occupancy !== 3'd3 || upd_pc !== 64'h804) begin
            n_err++; $display("FAIL enq_and_resolve: occ=%0d upc=%h want 3/804", occupancy, upd_pc);
        end
        while (mq.size() != 0) res(mq[0].taken, mq[0].target);
    endtask

    task automatic test_underflow();
        logic [CNT_W-1:0] br_before;
        br_before = 4'(exp_br);
        res(1'b1, 64'h123);
        n_vec++;
        if (err_underflow !== 1'b1 || upd_valid !== 1'b0 || flush !== 1'b0) begin
            n_err++; $display("FAIL underflow: err=%0b upd=%0b flush=%0b want 1/0/0",
                              err_underflow, upd_valid, flush);
        end
        n_vec++;
        if (br_count !== br_before) begin
            n_err++; $display("FAIL underflow_br: got %0d want %0d", br_count, br_before);
        end
        repeat (3) cyc(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0);
        n_vec++;
        if (err_underflow !== 1'b1) begin
            n_err++; $display("FAIL underflow_sticky: got %0b want 1", err_underflow);
        end
    endtask

    task automatic test_random();
        logic        pv, pt, rv, rt;
        logic [63:0] ppc, ptg, rtg;
        for (int n = 0; n < 300; n++) begin
            pv  = ($urandom_range(0, 1) == 1);
            pt  = $urandom_range(0, 1) == 1;
            ppc = {32'd0, $urandom} & ~64'd3;
            ptg = {32'd0, $urandom} & ~64'd3;
            rv  = ($urandom_range(0, 9) < 4);
            if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
                rt = mq[0].taken;
                rtg = ($urandom_range(0, 3) != 0) ? mq[0].target : ({32'd0, $urandom} & ~64'd3);
            end else begin
                rt  = $urandom_range(0, 1) == 1;
                rtg = {32'd0, $urandom} & ~64'd3;
            end
            if (!pred_ready) pv = pv && ($urandom_range(0, 1) == 1);
            cyc(pv, pt, ppc, ptg, rv, rt, rtg);
            n_vec++;
            if (occupancy !== OCC_W'(mq.size()) || pred_ready !== (mq.size() < DEPTH)) begin
                n_err++; $display("FAIL rand_queue[%0d]: occ=%0d ready=%0b want %0d", n,
                                  occupancy, pred_ready, mq.size());
            end
            n_vec++;
            if (flush !== exp_flush || upd_valid !== exp_upd || err_underflow !== exp_err) begin
                n_err++; $display("FAIL rand_pulses[%0d]: flush=%0b upd=%0b err=%0b want %0b/%0b/%0b",
                                  n, flush, upd_valid, err_underflow, exp_flush, exp_upd, exp_err);
            end
            n_vec++;
            if (br_count !== CNT_W'(exp_br) || mispred_count !== CNT_W'(exp_mis)) begin
                n_err++; $display("FAIL rand_counters[%0d]: br=%0d mis=%0d want %0d/%0d", n,
                                  br_count, mispred_count, exp_br, exp_mis);
            end
            if (exp_flush) begin
                n_vec++;
                if (redirect_pc !== exp_redirect) begin
                    n_err++; $display("FAIL rand_redirect[%0d]: got %h want %h", n, redirect_pc, exp_redirect);
                end
            end
            if (exp_upd) begin
                n_vec++;
                if (upd_pc !== exp_upd_pc || upd_taken !== exp_upd_taken) begin
                    n_err++; $display("FAIL rand_update[%0d]: pc=%h t=%0b want %h/%0b", n,
                                      upd_pc, upd_taken, exp_upd_pc, exp_upd_taken);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            enq(1'b0, 64'hC00, 64'hC40);
            res(1'b1, 64'hD00);
        end
        n_vec++;
        if (br_count !== 4'hF || mispred_count !== 4'hF) begin
            n_err++; $display("FAIL saturation: br=%0d mis=%0d want 15/15", br_count, mispred_count);
        end
        enq(1'b1, 64'hE00, 64'hE40);
        res(1'b1, 64'hE40);
        n_vec++;
        if (br_count !== 4'hF || upd_valid !== 1'b1) begin
            n_err++; $display("FAIL saturation_hold: br=%0d upd=%0b want 15/1", br_count, upd_valid);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b0;
        pred_valid = 1'b0; pred_taken = 1'b0; pred_pc = '0; pred_target = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        exp_redirect = '0; exp_upd_pc = '0; exp_upd_taken = 1'b0;
        model_reset();
        test_reset();
        test_correct_resolve();
        test_mispredict_taken();
        test_mispredict_same_cycle_enq();
        test_pc_wrap();
        test_full();
        test_underflow();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Tracks every conditional branch prediction made in IF until the branch resolves in EX.
- On resolution it compares the predicted and actual outcomes. On a mismatch it issues a registered flush and redirect PC, and it always emits an update write for the predictor's history table.
- It is the consumer and checker side of the predictor interface and sits beside the EX stage of the pipelined core.
- It also keeps branch and mispredict statistics for the data-output logger.

Parameters:
- DEPTH, 4, in-flight prediction queue entries (power of two, ≥2)
- PC_W, 64, PC / target width
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- pred_valid  in  1  IF has predicted a branch this cycle (enqueue)
- pred_taken  in  1  predicted direction
- pred_pc  in  PC_W  PC of the predicted branch
- pred_target  in  PC_W  predicted taken-target
- pred_ready  out  1  queue can accept; IF stalls while low
- res_valid  in  1  EX resolves the oldest branch this cycle
- res_taken  in  1  actual outcome
- res_target  in  PC_W  computed branch target
- flush  out  1  one-cycle mispredict pulse
- redirect_pc  out  PC_W  correct fetch PC, valid with flush
- upd_valid  out  1  predictor table write strobe
- upd_pc  out  PC_W  PC of the resolved branch
- upd_taken  out  1  actual outcome to train on
- br_count  out  CNT_W  resolved branches
- mispred_count  out  CNT_W  mispredicted branches
- err_underflow  out  1  sticky: res_valid seen with queue empty
- occupancy  out  log2(DEPTH)+1  entries in flight

Behaviour:
- Reset values:
  - pred_ready=1; occupancy=0.
  - flush=0, redirect_pc=0, upd_valid=0, upd_pc=0, upd_taken=0.
  - br_count=0, mispred_count=0, err_underflow=0.
  - Reset mid-operation discards all entries and any pending pulse.
- Queue:
  - Circular FIFO with read/write pointers and a count.
  - pred_ready = (count != DEPTH), combinational from registered count; there is no full-bypass.
  - Enqueue when pred_valid && pred_ready.
  - pred_valid while not ready is ignored; that is a caller error and is not stored.
- Resolve when res_valid && count != 0: pop the head entry {taken, pc, target}.
  - mispredict = (head.taken != res_taken) || (res_taken && head.target != res_target).
  - Next cycle (latency 1, registered):
    - upd_valid=1, upd_pc=head.pc, upd_taken=res_taken.
    - br_count increments.
    - If mispredict: flush=1, redirect_pc = res_taken ? res_target : head.pc+4 (mod 2^PC_W), and mispred_count increments.
  - flush and upd_valid are one-cycle pulses.
- Mispredict squash:
  - The whole queue is cleared: pointers reset, count=0. All younger entries are wrong-path.
  - An enqueue in the same cycle is dropped.
- Simultaneous enqueue and non-mispredict resolve: both occur and count is unchanged; legal at full only if pred_ready was high, so never at full.
- Underflow: res_valid with count==0 makes no pop, no pulses, no counter change, and sets err_underflow. err_underflow clears only on reset.
- Statistics counters saturate at all-ones and do not wrap.
- During the flush cycle new enqueues are accepted normally; those are correct-path fetches.

Decomposition:
- Shared package/include `branch_pkg`:
  - entry record layout {taken, pc[PC_W], target[PC_W]} and its width constant;
  - PC increment constant 4;
  - occupancy width function clog2.
- One sub-module: `pred_queue`, a parameterised FIFO with push/pop/clear and a count output.
- Compare, pulse registers and counters stay in the top module.

Test Plan:
- Reset low for 2 cycles mid-traffic with 3 entries queued -> occupancy=0, pred_ready=1, all pulses 0, counters 0.
- Enqueue {taken=1, pc=0x100, tgt=0x140}; resolve taken, target 0x140 -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=1, flush=0, br_count=1.
- Enqueue {taken=0, pc=0x200}, then 2 more entries; resolve taken, target 0x180 -> flush=1, redirect_pc=0x180, mispred_count=1, occupancy=0 afterwards.
- Enqueue {taken=1, pc=0x300, tgt=0x340}; resolve not-taken with a same-cycle enqueue -> redirect_pc=0x304, flush=1, the same-cycle enqueue is dropped, occupancy=0.
- Fill 4 entries -> pred_ready=0 and a 5th pred_valid is ignored; one correct resolve -> pred_ready=1, occupancy=3.
- res_valid with an empty queue -> err_underflow=1 and stays high; br_count unchanged; no upd_valid.
